// File: rtl/oursring_typedef.sv
// oursring_typedef: shared station transaction types for the oursring debug/host path.
// Used by the sd arbiter and anything else that talks sd_info_t on the ring.
package oursring_typedef;

    localparam int SD_INFO_W = 106;

    typedef enum logic [1:0] {
        ST_RD  = 2'd0,
        ST_WR  = 2'd1,
        ST_RSP = 2'd2,
        ST_ERR = 2'd3
    } st_type_e;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_DR_OUT       = 2'd1,
        ST_INDIRECT_IN  = 2'd2,
        ST_INDIRECT_OUT = 2'd3
    } st_state_e;

    typedef struct packed {
        st_type_e     typ;
        logic [39:0]  addr;
        logic [63:0]  data;
    } sd_info_t;

    // Error response echoing the request address with no payload.
    function automatic sd_info_t sd_rsp_err(input logic [39:0] addr);
        sd_info_t r;
        r.typ  = ST_ERR;
        r.addr = addr;
        r.data = 64'd0;
        return r;
    endfunction

    // Only reads and writes are legitimate requests; RSP/ERR are response-only types.
    function automatic logic sd_is_req(input st_type_e typ);
        return (typ == ST_RD) || (typ == ST_WR);
    endfunction

endpackage

// File: rtl/oursring_rr_pick.sv
// oursring_rr_pick: combinational round-robin picker. Returns the first valid
// bit at or after ptr (wrapping) as a one-hot grant plus its index.
module oursring_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] sel_s;

    // Scan from ptr upward, wrapping, and stop at the first requester found.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sel_s = '0;
        for (int k = 0; k < N; k++) begin
            sel_s = IW'((int'(ptr) + k) % N);
            if (!any && valid[sel_s]) begin
                any          = 1'b1;
                grant[sel_s] = 1'b1;
                idx          = sel_s;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/oursring_sd_arb.sv
// oursring_sd_arb: round-robin arbiter/sequencer sharing one ring station channel
// among N_REQ requesters. Define OURSRING_SD_ARB_STAT_EN to add statistics counters.
module oursring_sd_arb
    import oursring_typedef::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic     [N_REQ-1:0]  req_valid,
    output logic     [N_REQ-1:0]  req_ready,
    input  sd_info_t [N_REQ-1:0]  req_info,
    output logic     [N_REQ-1:0]  rsp_valid,
    input  logic     [N_REQ-1:0]  rsp_ready,
    output sd_info_t              rsp_info,
    output logic                  ring_req_valid,
    input  logic                  ring_req_ready,
    output sd_info_t              ring_req_info,
    input  logic                  ring_rsp_valid,
    output logic                  ring_rsp_ready,
    input  sd_info_t              ring_rsp_info
`ifdef OURSRING_SD_ARB_STAT_EN
    ,
    output logic     [15:0]       stat_timeout_cnt,
    output logic     [15:0]       stat_stray_cnt,
    output logic     [15:0]       stat_illegal_cnt
`endif
);

    localparam int IW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [N_REQ-1:0] OH_ONE = N_REQ'(1);

    st_state_e          state_r;
    logic [IW-1:0]      ptr_r;
    logic [IW-1:0]      owner_r;
    sd_info_t           req_r;
    sd_info_t           rsp_r;
    logic [CW-1:0]      cnt_r;
    logic               ring_req_valid_r;
    logic [N_REQ-1:0]   rsp_valid_r;
    logic               ring_rsp_ready_r;

    logic [N_REQ-1:0]   pick_grant_s;
    logic [IW-1:0]      pick_idx_s;
    logic               pick_any_s;
    logic               timeout_s;
    logic [IW-1:0]      ptr_next_s;
    sd_info_t           ring_rsp_fix_s;

    oursring_rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr_r),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .any   (pick_any_s)
    );

    assign req_ready      = (state_r == ST_IDLE && !rst) ? pick_grant_s : '0;
    assign rsp_valid      = rsp_valid_r;
    assign rsp_info       = rsp_r;
    assign ring_req_valid = ring_req_valid_r;
    assign ring_req_info  = req_r;
    assign ring_rsp_ready = ring_rsp_ready_r;
    assign timeout_s      = (TIMEOUT_CYC != 0) && (cnt_r == CW'(TO_LAST));
    assign ptr_next_s     = (owner_r == IW'(N_REQ - 1)) ? '0 : owner_r + IW'(1);

    // A ring "response" carrying a request type is malformed and reported as ERR.
    always_comb begin
        ring_rsp_fix_s = ring_rsp_info;
        if (sd_is_req(ring_rsp_info.typ)) begin
            ring_rsp_fix_s.typ = ST_ERR;
        end else begin
            ring_rsp_fix_s.typ = ring_rsp_info.typ;
        end
    end

    // Transaction sequencer: grant, ring request, wait for response, return to owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            ptr_r            <= '0;
            owner_r          <= '0;
            req_r            <= '0;
            rsp_r            <= '0;
            cnt_r            <= '0;
            ring_req_valid_r <= 1'b0;
            rsp_valid_r      <= '0;
            ring_rsp_ready_r <= 1'b0;
        end else begin
            ring_rsp_ready_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        owner_r          <= pick_idx_s;
                        req_r            <= req_info[pick_idx_s];
                        ring_req_valid_r <= sd_is_req(req_info[pick_idx_s].typ);
                        state_r          <= ST_DR_OUT;
                    end
                end
                ST_DR_OUT: begin
                    // Illegal requests pass through here with the ring request
                    // suppressed, so their error comes back two cycles after grant.
                    if (!sd_is_req(req_r.typ)) begin
                        rsp_r       <= sd_rsp_err(req_r.addr);
                        rsp_valid_r <= OH_ONE << owner_r;
                        state_r     <= ST_INDIRECT_OUT;
                    end else if (ring_req_ready) begin
                        ring_req_valid_r <= 1'b0;
                        cnt_r            <= '0;
                        state_r          <= ST_INDIRECT_IN;
                    end
                end
                ST_INDIRECT_IN: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (ring_rsp_valid) begin
                        rsp_r       <= ring_rsp_fix_s;
                        rsp_valid_r <= OH_ONE << owner_r;
                        state_r     <= ST_INDIRECT_OUT;
                    end else if (timeout_s) begin
                        rsp_r       <= sd_rsp_err(req_r.addr);
                        rsp_valid_r <= OH_ONE << owner_r;
                        state_r     <= ST_INDIRECT_OUT;
                    end
                end
                ST_INDIRECT_OUT: begin
                    if (rsp_ready[owner_r]) begin
                        rsp_valid_r <= '0;
                        ptr_r       <= ptr_next_s;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef OURSRING_SD_ARB_STAT_EN
    logic timeout_evt_s;
    logic stray_evt_s;
    logic illegal_evt_s;

    assign timeout_evt_s = (state_r == ST_INDIRECT_IN) && !ring_rsp_valid && timeout_s;
    assign stray_evt_s   = ring_rsp_valid && ring_rsp_ready_r && (state_r != ST_INDIRECT_IN);
    assign illegal_evt_s = (state_r == ST_IDLE) && pick_any_s && !sd_is_req(req_info[pick_idx_s].typ);

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_timeout_cnt <= 16'd0;
            stat_stray_cnt   <= 16'd0;
            stat_illegal_cnt <= 16'd0;
        end else begin
            if (timeout_evt_s && stat_timeout_cnt != 16'hFFFF) begin
                stat_timeout_cnt <= stat_timeout_cnt + 16'd1;
            end
            if (stray_evt_s && stat_stray_cnt != 16'hFFFF) begin
                stat_stray_cnt <= stat_stray_cnt + 16'd1;
            end
            if (illegal_evt_s && stat_illegal_cnt != 16'hFFFF) begin
                stat_illegal_cnt <= stat_illegal_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
